seq_mul_engine: RTL and testbench

- Memory-walking multiply engine for the program-3 class of workloads: reads NPAIRS operand pairs from byte-wide data memory, multiplies each pair, writes the double-width product back.
- Generalises the fixed 16-bit signed case: parametrised operand width, pair count and base addresses, plus a run-time signed/unsigned mode.
- Sits beside the data memory inside top_level and drives its byte port.
- Multiplication is iterative radix-2 Booth, one step per cycle.

---
 rtl/seq_mul_engine_pkg.sv | 24 ++
 rtl/seq_mul_engine_booth.sv | 66 ++++++
 rtl/seq_mul_engine.sv | 150 +++++++++++++++
 tb/tb_seq_mul_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_engine_pkg.sv
// Shared types and sizing helpers for the sequential multiply engine.
package seq_mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MUL,
        STORE,
        DONE
    } state_t;

    function automatic int op_bytes(input int op_w);
        return op_w / 8;
    endfunction

    // Cycles spent on one operand pair: two loads, OP_W+1 Booth cycles, store.
    function automatic int pair_latency(input int op_w);
        return 4 * op_bytes(op_w) + op_w + 1;
    endfunction

    localparam int PAIR_LAT_DEFAULT = pair_latency(16);

endpackage

// File: rtl/seq_mul_engine_booth.sv
// Iterative radix-2 Booth multiplier: the start edge performs step 1, then one step per cycle.
module booth_mul_iter
    import seq_mul_pkg::*;
#(
    parameter int OP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W:0]     a_ext,
    input  logic [OP_W:0]     b_ext,
    output logic              busy,
    output logic              valid,
    output logic [2*OP_W-1:0] product
);
    localparam int XW = OP_W + 1;
    localparam int RW = 2 * XW + 2;
    localparam int SW = $clog2(OP_W + 1);

    // r = {acc (XW+1 bits, one guard bit), multiplier q (XW bits), q_minus_1}
    logic [RW-1:0] r;
    logic [XW-1:0] m;
    logic [SW-1:0] steps;

    function automatic logic [RW-1:0] booth_step(input logic [RW-1:0] cur, input logic [XW-1:0] mc);
        logic [XW:0] acc;
        logic [XW:0] mx;
        acc = cur[RW-1 -: XW+1];
        mx  = {mc[XW-1], mc};
        case (cur[1:0])
            2'b01:   acc = acc + mx;
            2'b10:   acc = acc - mx;
            default: acc = acc;
        endcase
        return {acc[XW], acc, cur[XW:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r     <= '0;
            m     <= '0;
            steps <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                r     <= booth_step({{(XW+1){1'b0}}, b_ext, 1'b0}, a_ext);
                m     <= a_ext;
                steps <= SW'(OP_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                r <= booth_step(r, m);
                if (steps == '0) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end else begin
                    steps <= steps - 1'b1;
                end
            end
        end
    end

    assign product = r[2*OP_W:1];

endmodule

// File: rtl/seq_mul_engine.sv
// Memory-walking multiply engine: loads operand pairs, Booth-multiplies, stores products big-endian.
// Optional cycle_cnt output enabled by macro SEQ_MUL_CYCLE_CNT_EN.
//   state  | meaning
//   IDLE   | held in reset, waiting for the first low-reset edge
//   LOAD_A | capture operand A, MS byte first
//   LOAD_B | capture operand B; Booth start on its last byte
//   MUL    | Booth iterations, left on the multiplier's valid pulse
//   STORE  | write product bytes, MS byte first
//   DONE   | run finished, no memory access
module seq_mul_engine
    import seq_mul_pkg::*;
#(
    parameter int OP_W     = 16,
    parameter int NPAIRS   = 16,
    parameter int AW       = 8,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          signed_mode,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic          done
`ifdef SEQ_MUL_CYCLE_CNT_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);
    localparam int OB = op_bytes(OP_W);
    localparam int CW = $clog2(OP_W + 1);
    localparam int PW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [AW-1:0] STRIDE = AW'(2 * OB);

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_load;
    logic [PW-1:0]     pair;
    logic [AW-1:0]     src_ptr;
    logic [AW-1:0]     dst_ptr;
    logic              mode;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [OP_W-1:0]   b_full;
    logic [OP_W:0]     a_ext;
    logic [OP_W:0]     b_ext;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_valid;
    logic [2*OP_W-1:0] product;
    logic              last_pair;

    assign last_pair = (pair == PW'(NPAIRS - 1));
    assign b_full    = (b_reg << 8) | OP_W'(mem_rd_data);
    assign a_ext     = {mode & a_reg[OP_W-1], a_reg};
    assign b_ext     = {mode & b_full[OP_W-1], b_full};
    assign mul_start = (state == LOAD_B) && (cnt == '0);

    booth_mul_iter #(.OP_W(OP_W)) u_booth (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a_ext   (a_ext),
        .b_ext   (b_ext),
        .busy    (mul_busy),
        .valid   (mul_valid),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = LOAD_A;
            LOAD_A:  if (cnt == '0) next_state = LOAD_B;
            LOAD_B:  if (cnt == '0) next_state = MUL;
            MUL:     if (mul_valid && !mul_busy) next_state = STORE;
            STORE:   if (cnt == '0) next_state = last_pair ? DONE : LOAD_A;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = AW'(SRC_BASE);
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        done        = 1'b0;
        case (state)
            LOAD_A: mem_addr = src_ptr + AW'(OB - 1) - AW'(cnt);
            LOAD_B: mem_addr = src_ptr + AW'(2 * OB - 1) - AW'(cnt);
            STORE: begin
                mem_addr    = dst_ptr + AW'(2 * OB - 1) - AW'(cnt);
                mem_wr_en   = 1'b1;
                mem_wr_data = 8'(product >> {cnt, 3'b000});
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Byte counter is a down-counter; its value is also the byte's position from the LS end.
    always_comb begin
        cnt_load = '0;
        case (next_state)
            LOAD_A, LOAD_B: cnt_load = CW'(OB - 1);
            STORE:          cnt_load = CW'(2 * OB - 1);
            default:        cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pair    <= '0;
            src_ptr <= AW'(SRC_BASE);
            dst_ptr <= AW'(DST_BASE);
            mode    <= signed_mode;
            a_reg   <= '0;
            b_reg   <= '0;
        end else begin
            if (next_state != state) cnt <= cnt_load;
            else if (cnt != '0)      cnt <= cnt - 1'b1;
            if (state == LOAD_A) a_reg <= (a_reg << 8) | OP_W'(mem_rd_data);
            if (state == LOAD_B) b_reg <= b_full;
            if (state == STORE && cnt == '0) begin
                pair    <= pair + 1'b1;
                src_ptr <= src_ptr + STRIDE;
                dst_ptr <= dst_ptr + STRIDE;
            end
        end
    end

`ifdef SEQ_MUL_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else if (state != IDLE && state != DONE && cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_seq_mul_engine.sv
// Self-checking bench for seq_mul_engine: vector table, random pairs, mid-run reset, 8-bit variant.
module tb_seq_mul_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst16 = 1'b1, sm16 = 1'b1, we16, done16;
    logic [7:0] addr16, wd16, rd16;
    logic       rst8 = 1'b1, sm8 = 1'b1, we8, done8;
    logic [7:0] addr8, wd8, rd8;
`ifdef SEQ_MUL_CYCLE_CNT_EN
    logic [15:0] cc16, cc8;
`endif

    logic [7:0] mem16 [256];
    logic [7:0] mem8  [256];
    logic [7:0] img   [256];
    logic       pl16 = 1'b0, pl8 = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

    assign rd16 = mem16[addr16];
    assign rd8  = mem8[addr8];

    always @(posedge clk) begin
        if (pl16)      mem16[pl_addr] <= pl_data;
        else if (we16) mem16[addr16]  <= wd16;
    end

    always @(posedge clk) begin
        if (pl8)      mem8[pl_addr] <= pl_data;
        else if (we8) mem8[addr8]   <= wd8;
    end

    seq_mul_engine dut16 (
        .clk(clk), .reset(rst16), .signed_mode(sm16), .mem_addr(addr16),
        .mem_rd_data(rd16), .mem_wr_en(we16), .mem_wr_data(wd16), .done(done16)
`ifdef SEQ_MUL_CYCLE_CNT_EN
        , .cycle_cnt(cc16)
`endif
    );

    seq_mul_engine #(.OP_W(8), .NPAIRS(2), .DST_BASE(32)) dut8 (
        .clk(clk), .reset(rst8), .signed_mode(sm8), .mem_addr(addr8),
        .mem_rd_data(rd8), .mem_wr_en(we8), .mem_wr_data(wd8), .done(done8)
`ifdef SEQ_MUL_CYCLE_CNT_EN
        , .cycle_cnt(cc8)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          sgn;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: exact integer product of the operands as numbers, truncated to 32 bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input bit sgn);
        longint x, y;
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    function automatic logic [15:0] op_a(input int j);
        return {img[4*j], img[4*j+1]};
    endfunction

    function automatic logic [15:0] op_b(input int j);
        return {img[4*j+2], img[4*j+3]};
    endfunction

    function automatic logic [31:0] prod16(input int j);
        return {mem16[64+4*j], mem16[65+4*j], mem16[66+4*j], mem16[67+4*j]};
    endfunction

    task automatic fill_random_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        for (int i = 0; i < 64; i++)  img[i] = 8'($urandom);
        for (int i = 64; i < 128; i++) img[i] = 8'hAA;
    endtask

    task automatic preload(input bit to8);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl16    = !to8;
            pl8     = to8;
            pl_addr = 8'(i);
            pl_data = img[i];
        end
        @(negedge clk);
        pl16 = 1'b0;
        pl8  = 1'b0;
    endtask

    // One run of the default engine; n returns the edge count after the first low-reset edge,
    // or -1 when aborted by a reset raised at pair 5's first store byte.
    task automatic run16(input bit mode, input bit abort_pair5, output int n);
        int writes;
        sm16  = mode;
        rst16 = 1'b1;
        preload(1'b0);
        @(negedge clk);
        check("rst_done", done16, 0);
        check("rst_wr_en", we16, 0);
        check("rst_addr", addr16, 0);
        check("rst_wr_data", wd16, 0);
        rst16 = 1'b0;
        @(posedge clk);
        n = 0;
        writes = 0;
        while (1) begin
            #1;
            if (we16) begin
                writes++;
                check("wr_addr_range", (addr16 >= 8'd64 && addr16 < 8'd128), 1);
                if (abort_pair5 && addr16 == 8'd84) begin
                    rst16 = 1'b1;
                    @(posedge clk);
                    #1;
                    check("abort_wr_en", we16, 0);
                    check("abort_done", done16, 0);
                    check("abort_addr", addr16, 0);
                    n = -1;
                    return;
                end
            end
            if (done16 || n >= 1000) break;
            if (n == 0) sm16 = ~mode;
            @(posedge clk);
            n++;
        end
        check("done_edges", n, 400);
        check("write_count", writes, 64);
`ifdef SEQ_MUL_CYCLE_CNT_EN
        check("cycle_cnt", cc16, 400);
`endif
        for (int j = 0; j < 16; j++)
            check($sformatf("pair%0d_mode%0d", j, mode), prod16(j), ref_mul(op_a(j), op_b(j), mode));
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done16, 1);
        check("done_no_write", we16, 0);
`ifdef SEQ_MUL_CYCLE_CNT_EN
        check("cycle_cnt_frozen", cc16, 400);
`endif
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 32'h3FFF_8000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001};
        vecs[6] = '{16'h0001, 16'hFFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{16'h0001, 16'hFFFF, 1'b0, 32'h0000_FFFF};
        vecs[8] = '{16'h0000, 16'h1234, 1'b1, 32'h0000_0000};

        for (int i = 0; i < 9; i++) begin
            fill_random_img();
            {img[0], img[1]} = vecs[i].a;
            {img[2], img[3]} = vecs[i].b;
            run16(vecs[i].sgn, 1'b0, n);
            check($sformatf("vec%0d", i), prod16(0), vecs[i].p);
        end

        fill_random_img();
        run16(1'b1, 1'b0, n);
        fill_random_img();
        run16(1'b0, 1'b0, n);

        fill_random_img();
        run16(1'b1, 1'b1, n);
        check("abort_taken", n, -1);
        for (int j = 0; j < 5; j++)
            check($sformatf("kept_pair%0d", j), prod16(j), ref_mul(op_a(j), op_b(j), 1'b1));
        run16(1'b1, 1'b0, n);

        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[0] = 8'h80; img[1] = 8'h80; img[2] = 8'h7F; img[3] = 8'hFF;
        for (int i = 32; i < 36; i++) img[i] = 8'hAA;
        sm8  = 1'b1;
        rst8 = 1'b1;
        preload(1'b1);
        @(negedge clk);
        rst8 = 1'b0;
        @(posedge clk);
        n = 0;
        while (1) begin
            #1;
            if (done8 || n >= 200) break;
            @(posedge clk);
            n++;
        end
        check("w8_done_edges", n, 26);
        check("w8_pair0", {mem8[32], mem8[33]}, 16'h4000);
        check("w8_pair1", {mem8[34], mem8[35]}, 16'hFF81);
`ifdef SEQ_MUL_CYCLE_CNT_EN
        check("w8_cycle_cnt", cc8, 26);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
